// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - IF/MEM arbiter for one single-port fixed-latency unified memory
//
// Serialises instruction-fetch and data-access requests onto one memory port.
// Each access runs ISSUE -> WAIT -> ACK. A new grant can be made in IDLE, or in
// ACK for the requester that is not being acknowledged. MEM has priority by
// default. A streak counter forces an IF grant after MAX_MEM_STREAK consecutive
// MEM grants that IF had to wait through.
//
// Ports:
//   clk, reset              rising-edge clock, asynchronous active-low reset
//   if_req/if_addr          IF read request (level) and address
//   if_rdata/if_ack         fetched word and its one-cycle completion pulse
//   mem_req/mem_we/mem_addr/mem_wdata   MEM request, direction, address, store data
//   mem_rdata/mem_ack       load data and its one-cycle completion pulse
//   ram_en/ram_we/ram_addr/ram_wdata/ram_rdata   memory port
//   stall_if/stall_mem      request pending without ack (combinational)
//   busy                    arbiter is not IDLE
module unified_mem_arbiter #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int LATENCY        = 2,
    parameter int MAX_MEM_STREAK = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          mem_req,
    input  logic          mem_we,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_wdata,
    output logic [DW-1:0] mem_rdata,
    output logic          mem_ack,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          stall_if,
    output logic          stall_mem,
    output logic          busy
);

    localparam int CW = 4;
    localparam logic [CW-1:0] LAT_INIT   = CW'(LATENCY);
    localparam logic [CW-1:0] STREAK_MAX = CW'(MAX_MEM_STREAK);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] streak_q, streak_d;
    logic          owner_mem_q, owner_mem_d;   // 1: access in flight belongs to MEM
    logic          ram_en_q, ram_en_d;
    logic          ram_we_q, ram_we_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_wdata_q, ram_wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] mem_rdata_q, mem_rdata_d;
    logic          if_ack_q, if_ack_d;
    logic          mem_ack_q, mem_ack_d;
    logic          busy_q, busy_d;

    logic can_grant;
    logic mem_ok;
    logic if_ok;
    logic grant_mem;
    logic grant_if;

    always_comb begin
        // In ACK the requester just served is excluded so its still-high level
        // request is not mistaken for a new one.
        can_grant = (state_q == S_IDLE) || (state_q == S_ACK);
        mem_ok    = mem_req && !((state_q == S_ACK) && owner_mem_q);
        if_ok     = if_req && !((state_q == S_ACK) && !owner_mem_q);
        grant_mem = can_grant && mem_ok && !(if_ok && (streak_q == STREAK_MAX));
        grant_if  = can_grant && if_ok && !grant_mem;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        streak_d    = streak_q;
        owner_mem_d = owner_mem_q;
        ram_en_d    = 1'b0;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_ack_d    = 1'b0;
        mem_ack_d   = 1'b0;

        case (state_q)
            S_IDLE, S_ACK: begin
                if (grant_mem) begin
                    ram_addr_d  = mem_addr;
                    ram_we_d    = mem_we;
                    ram_wdata_d = mem_wdata;
                    owner_mem_d = 1'b1;
                    // Only MEM grants that IF had to wait through count.
                    if (if_req) begin
                        streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;
                    end else begin
                        streak_d = '0;
                    end
                end else if (grant_if) begin
                    ram_addr_d  = if_addr;
                    ram_we_d    = 1'b0;
                    owner_mem_d = 1'b0;
                    streak_d    = '0;
                end

                if (grant_mem || grant_if) begin
                    ram_en_d = 1'b1;
                    cnt_d    = LAT_INIT;
                    state_d  = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_ISSUE: begin
                cnt_d   = cnt_q - 1'b1;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                // cnt reaching zero marks the cycle in which ram_rdata is valid.
                if (cnt_q == '0) begin
                    if (owner_mem_q) begin
                        mem_ack_d = 1'b1;
                        if (!ram_we_q) begin
                            mem_rdata_d = ram_rdata;
                        end
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = ram_rdata;
                    end
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            streak_q    <= '0;
            owner_mem_q <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            streak_q    <= streak_d;
            owner_mem_q <= owner_mem_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_ack_q    <= if_ack_d;
            mem_ack_q   <= mem_ack_d;
            busy_q      <= busy_d;
        end
    end

    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign if_ack    = if_ack_q;
    assign mem_ack   = mem_ack_q;
    assign busy      = busy_q;
    assign stall_if  = if_req & ~if_ack_q;
    assign stall_mem = mem_req & ~mem_ack_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - directed self-checking bench for unified_mem_arbiter
module tb_unified_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        stall_if;
    logic        stall_mem;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    unified_mem_arbiter #(
        .AW(32), .DW(32), .LATENCY(2), .MAX_MEM_STREAK(4)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory model: writes land on the ram_en edge; read data is presented
    // exactly two cycles after the ram_en cycle, poison otherwise.
    logic [31:0] mem_arr [logic [31:0]];
    logic [31:0] p1 = '0, p2 = '0;
    logic        v1 = 1'b0, v2 = 1'b0;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        case (a)
            32'h40:  return 32'h8C0A_0004;
            32'h44:  return 32'h1111_2222;
            default: return {16'hA5A5, a[15:0]};
        endcase
    endfunction

    always @(posedge clk) begin
        v1 <= 1'b0;
        if (ram_en) begin
            if (ram_we) mem_arr[ram_addr] = ram_wdata;
            else begin
                v1 <= 1'b1;
                p1 <= rd_word(ram_addr);
            end
        end
        v2 <= v1;
        p2 <= p1;
    end

    assign ram_rdata = v2 ? p2 : 32'hBAD0_0BAD;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int ack_seen;

    initial begin
        reset = 1'b0; if_req = 1'b1; if_addr = 32'h40;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
        ack_seen = 0;

        // Reset held with if_req asserted
        repeat (3) step();
        check_eq("rst_ram_en", ram_en, 0);
        check_eq("rst_if_ack", if_ack, 0);
        check_eq("rst_mem_ack", mem_ack, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_if_rdata", if_rdata, 0);
        check_eq("rst_mem_rdata", mem_rdata, 0);
        check_eq("rst_ram_addr", ram_addr, 0);

        // Single IF read of 0x40; cycle 0 is the release cycle
        reset = 1'b1;
        check_eq("if_c0_stall", stall_if, 1);
        step();
        check_eq("if_c1_ram_en", ram_en, 1);
        check_eq("if_c1_addr", ram_addr, 32'h40);
        check_eq("if_c1_we", ram_we, 0);
        check_eq("if_c1_busy", busy, 1);
        step();
        check_eq("if_c2_ram_en", ram_en, 0);
        check_eq("if_c2_stall", stall_if, 1);
        step();
        check_eq("if_c3_ack", if_ack, 0);
        check_eq("if_c3_stall", stall_if, 1);
        step();
        check_eq("if_c4_ack", if_ack, 1);
        check_eq("if_c4_rdata", if_rdata, 32'h8C0A_0004);
        check_eq("if_c4_stall", stall_if, 0);
        if_req = 1'b0;
        step();
        check_eq("if_c5_ack", if_ack, 0);
        check_eq("if_c5_busy", busy, 0);
        check_eq("if_c5_hold", if_rdata, 32'h8C0A_0004);

        // Contention: MEM write wins, IF granted in the ACK cycle
        if_req = 1'b1; if_addr = 32'h44;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h100; mem_wdata = 32'hDEAD_BEEF;
        check_eq("ct_c0_stall_mem", stall_mem, 1);
        step();
        check_eq("ct_c1_ram_en", ram_en, 1);
        check_eq("ct_c1_we", ram_we, 1);
        check_eq("ct_c1_addr", ram_addr, 32'h100);
        check_eq("ct_c1_wdata", ram_wdata, 32'hDEAD_BEEF);
        repeat (3) step();
        check_eq("ct_c4_mem_ack", mem_ack, 1);
        check_eq("ct_c4_mem_rdata", mem_rdata, 0);
        check_eq("ct_c4_if_ack", if_ack, 0);
        mem_req = 1'b0;
        step();
        check_eq("ct_c5_ram_en", ram_en, 1);
        check_eq("ct_c5_addr", ram_addr, 32'h44);
        check_eq("ct_c5_we", ram_we, 0);
        check_eq("ct_c5_mem_ack", mem_ack, 0);
        repeat (3) step();
        check_eq("ct_c8_if_ack", if_ack, 1);
        check_eq("ct_c8_if_rdata", if_rdata, 32'h1111_2222);
        if_req = 1'b0;
        step();
        check_eq("ct_c9_busy", busy, 0);

        // Read after write; inputs changed after the grant must be ignored
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h200; mem_wdata = 32'h1234_5678;
        step();
        check_eq("raw_c1_we", ram_we, 1);
        mem_we = 1'b0; mem_wdata = '0;
        repeat (2) step();
        check_eq("raw_c3_we", ram_we, 1);
        check_eq("raw_c3_wdata", ram_wdata, 32'h1234_5678);
        step();
        check_eq("raw_c4_ack", mem_ack, 1);
        check_eq("raw_c4_rdata_hold", mem_rdata, 0);
        step();
        check_eq("raw_c5_idle", busy, 0);
        step();
        check_eq("raw_c6_ram_en", ram_en, 1);
        check_eq("raw_c6_we", ram_we, 0);
        check_eq("raw_c6_addr", ram_addr, 32'h200);
        repeat (3) step();
        check_eq("raw_c9_ack", mem_ack, 1);
        check_eq("raw_c9_rdata", mem_rdata, 32'h1234_5678);
        mem_req = 1'b0;
        step();

        // Starvation guard: four MEM grants with IF waiting, then IF is forced,
        // then the streak is clear and MEM wins again
        for (int k = 0; k < 6; k++) begin
            if_req = 1'b1; if_addr = 32'h80;
            mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h300 + 32'(4 * k);
            step();
            check_eq($sformatf("stk%0d_addr", k), ram_addr,
                     (k == 4) ? 32'h80 : 32'h300 + 32'(4 * k));
            if_req = 1'b0; mem_req = 1'b0;
            repeat (3) step();
            if (k == 4) begin
                check_eq("stk4_if_ack", if_ack, 1);
                check_eq("stk4_if_rdata", if_rdata, 32'hA5A5_0080);
            end else begin
                check_eq($sformatf("stk%0d_mem_ack", k), mem_ack, 1);
                check_eq($sformatf("stk%0d_rdata", k), mem_rdata,
                         32'hA5A5_0300 + 32'(4 * k));
            end
            step();
        end

        // Reset during WAIT of a MEM read
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h320;
        repeat (2) step();
        check_eq("rmid_busy_before", busy, 1);
        reset = 1'b0;
        #1;
        check_eq("rmid_busy", busy, 0);
        check_eq("rmid_ram_en", ram_en, 0);
        check_eq("rmid_ram_addr", ram_addr, 0);
        check_eq("rmid_mem_rdata", mem_rdata, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            if (mem_ack) ack_seen++;
        end
        check_eq("rmid_no_ack", ack_seen, 0);
        mem_addr = 32'h324;
        reset = 1'b1;
        step();
        check_eq("rmid_c1_ram_en", ram_en, 1);
        check_eq("rmid_c1_addr", ram_addr, 32'h324);
        repeat (2) step();
        check_eq("rmid_c3_ack", mem_ack, 0);
        step();
        check_eq("rmid_c4_ack", mem_ack, 1);
        check_eq("rmid_c4_rdata", mem_rdata, 32'hA5A5_0324);
        mem_req = 1'b0;
        repeat (2) step();
        check_eq("end_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
Arbitrates one single-port unified memory between the pipeline's instruction-fetch (IF) stage and its data-access (MEM) stage. The memory has a fixed read/write latency. The block serialises accesses, returns data with a one-cycle acknowledge, and drives per-stage stall lines that the pipeline control uses to freeze IF or the whole pipe. It sits between the CPU core and the memory model that the CPU test bench instantiates.

Parameters:
AW, 32, address width in bits
DW, 32, data width in bits
LATENCY, 2, cycles from the ram_en cycle to valid ram_rdata; legal range 1..15
MAX_MEM_STREAK, 4, consecutive MEM grants allowed while IF waits before IF is forced; legal range 1..15

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
if_req  in  1  IF access request, level; IF accesses are always reads
if_addr  in  AW  IF address
if_rdata  out  DW  fetched word, valid when if_ack=1
if_ack  out  1  one-cycle completion pulse for IF
mem_req  in  1  MEM access request, level
mem_we  in  1  1 = write, 0 = read
mem_addr  in  AW  MEM address
mem_wdata  in  DW  MEM write data
mem_rdata  out  DW  load data, valid when mem_ack=1 and the access was a read
mem_ack  out  1  one-cycle completion pulse for MEM
ram_en  out  1  memory access strobe, one cycle per access
ram_we  out  1  memory write enable
ram_addr  out  AW  memory address
ram_wdata  out  DW  memory write data
ram_rdata  in  DW  memory read data
stall_if  out  1  if_req & ~if_ack (combinational)
stall_mem  out  1  mem_req & ~mem_ack (combinational)
busy  out  1  1 whenever the state is not IDLE

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; ram_en, ram_we, if_ack and mem_ack = 0; ram_addr, ram_wdata, if_rdata and mem_rdata = 0; cnt=0; streak=0. Any in-flight access is abandoned and no ack is issued for it.
- States: IDLE, ISSUE, WAIT, ACK. All outputs are registered except stall_if and stall_mem.
- Grant happens in IDLE or ACK at the clock edge. In ACK, the requester being acknowledged is excluded from the grant.
  - Default priority: MEM over IF.
  - If streak==MAX_MEM_STREAK and if_req=1, IF wins.
- On a grant, at the same edge: latch the granted address into ram_addr. For MEM, also latch ram_we=mem_we and ram_wdata=mem_wdata. For IF, set ram_we=0. Set ram_en=1, cnt=LATENCY, and go to ISSUE.
- ISSUE (1 cycle): ram_en=1. At the next edge, ram_en=0 and cnt decrements.
- The state is WAIT while cnt>0 after decrementing; cnt decrements each cycle.
- ram_rdata is valid in the cycle LATENCY cycles after the ISSUE cycle. In that cycle, capture ram_rdata into if_rdata or mem_rdata (reads only; on a write, mem_rdata holds its value). Pulse the matching ack for exactly 1 cycle and enter ACK.
- ram_addr, ram_we and ram_wdata stay stable from ISSUE through the end of the access.
- ACK: acks return to 0 at the next edge. If no grant, go to IDLE.
- Timing with LATENCY=2: req sampled at the end of cycle 0; ISSUE in cycle 1; rdata valid in cycle 3; ack in cycle 4. Back-to-back throughput is one access per LATENCY+2 cycles.
- Streak counter, updated at each grant:
  - MEM grant while if_req=1: streak+1, saturating at MAX_MEM_STREAK.
  - IF grant, or any grant while if_req=0: streak=0.
- Requests and addresses are sampled only at the grant edge. Changes afterwards are ignored until the next grant.
- A requester dropping its req mid-access does not cancel the access. The ack still pulses.
- Simultaneous if_req and mem_req in IDLE with streak below the limit: MEM is granted and IF stalls.
- mem_rdata and if_rdata hold their last captured value between acks.

Test Plan:
- Reset: hold reset=0 with if_req=1 → ram_en=0, both acks 0, busy=0, both rdata=0. Release at an edge → ISSUE on the first sampled req.
- Single IF read, LATENCY=2: if_addr=0x40 at cycle 0, memory word 0x8C0A0004 → ram_en=1 in cycle 1 only; if_ack=1 in cycle 4 with if_rdata=0x8C0A0004; stall_if=1 in cycles 0–3.
- Contention: if_req and mem_req both high at cycle 0, mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF →
  - MEM is granted: ram_we=1, ram_wdata=0xDEADBEEF, mem_ack in cycle 4.
  - IF is granted in the ACK cycle: ISSUE in cycle 5, if_ack in cycle 8.
- Starvation guard, MAX_MEM_STREAK=4: mem_req and if_req held high → exactly 4 MEM accesses, then 1 IF access, then MEM resumes; streak returns to 0 after the IF grant.
- Reset mid-access: assert reset=0 during WAIT of a MEM read → outputs clear immediately, no mem_ack ever pulses; the next request after release completes with normal latency.
- Read-after-write: write 0x12345678 to 0x200, then read 0x200 → mem_rdata=0x12345678 on the second mem_ack.
